// File: rtl/op_register_pkg.sv
// op_register_pkg: opcodes and FSM state encoding shared by op_register
package op_register_pkg;
   localparam logic [2:0] OP_CLR = 3'd0;
   localparam logic [2:0] OP_LD  = 3'd1;
   localparam logic [2:0] OP_INC = 3'd2;
   localparam logic [2:0] OP_DEC = 3'd3;
   localparam logic [2:0] OP_SHR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_ASR = 3'd6;
   localparam logic [2:0] OP_ROR = 3'd7;
   typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/op_register_shifter.sv
// op_register_shifter: combinational SHR/SHL/ASR/ROR by amt bits with last-bit-out carry
import op_register_pkg::*;
module op_register_shifter #(
   parameter int DATA_WIDTH = 16,
   parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] val,
   input  logic [2:0]            op,
   input  logic                  fill,
   input  logic [AMT_WIDTH-1:0]  amt,
   output logic [DATA_WIDTH-1:0] res,
   output logic                  carry_out
);
   logic                  top_fill;
   logic [DATA_WIDTH-1:0] right_src, right_res, left_res, first_r, first_l;
   assign top_fill  = op == OP_ASR ? val[DATA_WIDTH-1] : fill;
   assign right_src = op == OP_ROR ? val : {DATA_WIDTH{top_fill}};
   assign right_res = (val >> amt) | (right_src << (DATA_WIDTH - amt));
   assign left_res  = (val << amt) | ({DATA_WIDTH{fill}} >> (DATA_WIDTH - amt));
   assign first_r   = val >> (amt - 1'b1);
   assign first_l   = val << (amt - 1'b1);
   assign res       = op == OP_SHL ? left_res : right_res;
   assign carry_out = op == OP_SHL ? first_l[DATA_WIDTH-1] : first_r[0];
endmodule

// File: rtl/op_register.sv
// op_register: multi-mode datapath register with start/busy/done handshake; OP_REGISTER_BARREL_SHIFT_EN selects single-cycle barrel shifts
import op_register_pkg::*;
module op_register #(
   parameter int DATA_WIDTH = 16,
   parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [AMT_WIDTH-1:0]  amt,
   input  logic                  ser_in,
   input  logic [DATA_WIDTH-1:0] in,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  busy,
   output logic                  done,
   output logic                  carry,
   output logic                  zero
);
   logic [DATA_WIDTH-1:0] alu_out, sh_out;
   logic                  alu_c, sh_c, is_shift;
   assign is_shift = op >= OP_SHR;
   assign zero     = out == '0;
   assign alu_out  = op == OP_CLR ? '0 : op == OP_LD ? in : op == OP_INC ? out + 1'b1 :
                     op == OP_DEC ? out - 1'b1 : '0;
   assign alu_c    = op == OP_INC ? &out : op == OP_DEC ? ~|out : 1'b0;
`ifdef OP_REGISTER_BARREL_SHIFT_EN
   op_register_shifter #(.DATA_WIDTH(DATA_WIDTH), .AMT_WIDTH(AMT_WIDTH)) u_shifter (
      .val(out), .op(op), .fill(ser_in), .amt(amt), .res(sh_out), .carry_out(sh_c)
   );
   assign busy = 1'b0;
   // Every op completes on its accepting edge; a zero-length shift leaves out/carry alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out   <= '0;
         carry <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= start;
         if (start && (!is_shift || amt != '0)) begin
            out   <= is_shift ? sh_out : alu_out;
            carry <= is_shift ? sh_c : alu_c;
         end
      end
   end
`else
   state_t                state;
   logic [AMT_WIDTH-1:0]  cnt;
   logic [2:0]            op_q;
   logic                  fill_q;
   op_register_shifter #(.DATA_WIDTH(DATA_WIDTH), .AMT_WIDTH(AMT_WIDTH)) u_shifter (
      .val(out), .op(state == SHIFT ? op_q : op), .fill(state == SHIFT ? fill_q : ser_in),
      .amt(AMT_WIDTH'(1)), .res(sh_out), .carry_out(sh_c)
   );
   // Accept in IDLE, first shift step on the accepting edge, remaining steps one per edge in SHIFT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out    <= '0;
         carry  <= 1'b0;
         done   <= 1'b0;
         busy   <= 1'b0;
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= OP_CLR;
         fill_q <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               op_q   <= op;
               fill_q <= ser_in;
               if (!is_shift || amt != '0) begin
                  out   <= is_shift ? sh_out : alu_out;
                  carry <= is_shift ? sh_c : alu_c;
               end
               if (is_shift && amt > AMT_WIDTH'(1)) begin
                  state <= SHIFT;
                  busy  <= 1'b1;
                  cnt   <= amt - 1'b1;
               end else begin
                  done <= 1'b1;
               end
            end
         end else begin
            out   <= sh_out;
            carry <= sh_c;
            cnt   <= cnt - 1'b1;
            if (cnt == AMT_WIDTH'(1)) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_op_register.sv
// tb_op_register: scoreboard bench for op_register (default serial-shift build)
module tb_op_register;
   localparam int W  = 16;
   localparam int AW = 4;
`ifdef OP_REGISTER_BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif
   typedef struct packed {logic [W-1:0] out; logic c;} exp_t;
   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, ser_in = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [AW-1:0] amt = '0;
   logic [W-1:0]  in = '0;
   logic [W-1:0]  out;
   logic          busy, done, carry, zero;
   int            total = 0, bad = 0;
   exp_t          sb[$];
   exp_t          e;
   logic [W-1:0]  obs_out;
   logic          obs_c, obs_z;
   int            obs_busy, obs_cyc;

   op_register #(.DATA_WIDTH(W), .AMT_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .ser_in(ser_in),
      .in(in), .out(out), .busy(busy), .done(done), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   // Bit-by-bit reference of one operation; returns {carry, out}
   function automatic logic [W:0] model(input logic [2:0] o, input logic [AW-1:0] a, input logic f,
                                        input logic [W-1:0] d, input logic [W-1:0] v, input logic c);
      logic [W-1:0] r = v;
      logic         cc = c;
      case (o)
         3'd0: begin r = '0; cc = 1'b0; end
         3'd1: begin r = d; cc = 1'b0; end
         3'd2: begin cc = (v == 16'hFFFF); r = v + 16'd1; end
         3'd3: begin cc = (v == 16'h0000); r = v - 16'd1; end
         default:
            for (int i = 0; i < int'(a); i++) begin
               case (o)
                  3'd4:    begin cc = r[0];   r = {f, r[W-1:1]}; end
                  3'd5:    begin cc = r[W-1]; r = {r[W-2:0], f}; end
                  3'd6:    begin cc = r[0];   r = {r[W-1], r[W-1:1]}; end
                  default: begin cc = r[0];   r = {r[0], r[W-1:1]}; end
               endcase
            end
      endcase
      return {cc, r};
   endfunction

   // Issue one op and capture out/carry/zero at its done pulse (bounded wait)
   task automatic run_op(input logic [2:0] o, input logic [AW-1:0] a, input logic f,
                         input logic [W-1:0] d, input bit b2b);
      if (!b2b) @(negedge clk);
      start = 1'b1; op = o; amt = a; ser_in = f; in = d;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'($urandom); amt = AW'($urandom); ser_in = 1'($urandom); in = W'($urandom);
      obs_busy = 0; obs_cyc = 0; obs_out = 'x; obs_c = 1'bx; obs_z = 1'bx;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         obs_cyc++;
         if (done) begin
            obs_out = out; obs_c = carry; obs_z = zero;
            if (busy) obs_busy += 100;
            break;
         end
         if (busy) obs_busy++;
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({out, carry, busy, done, zero} !== {16'h0000, 4'b0001}) begin
         bad++;
         $display("FAIL reset: out=%h c=%b busy=%b done=%b zero=%b, want 0000 0 0 0 1", out, carry, busy, done, zero);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ld_inc();
      sb.push_back(exp_t'{16'hFFFF, 1'b0});
      run_op(3'd1, '0, 1'b0, 16'hFFFF, 1'b0);
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c} !== {e.out, e.c}) begin
         bad++;
         $display("FAIL ld: out=%h c=%b, want %h %b", obs_out, obs_c, e.out, e.c);
      end
      total++;
      if (obs_cyc !== 1 || obs_busy !== 0) begin
         bad++;
         $display("FAIL ld_timing: cyc=%0d busy=%0d, want 1 0", obs_cyc, obs_busy);
      end
      sb.push_back(exp_t'{16'h0000, 1'b1});
      run_op(3'd2, '0, 1'b0, '0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c, obs_z} !== {e.out, e.c, 1'b1}) begin
         bad++;
         $display("FAIL inc_wrap: out=%h c=%b z=%b, want %h %b 1", obs_out, obs_c, obs_z, e.out, e.c);
      end
      total++;
      if (obs_cyc !== 1 || obs_busy !== 0) begin
         bad++;
         $display("FAIL inc_timing: cyc=%0d busy=%0d, want 1 0", obs_cyc, obs_busy);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL inc_done_pulse: done=%b, want 0", done);
      end
   endtask

   task automatic test_shl();
      run_op(3'd1, '0, 1'b0, 16'h8001, 1'b0);
      sb.push_back(exp_t'{16'h0008, 1'b0});
      run_op(3'd5, 4'd3, 1'b0, '0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c} !== {e.out, e.c}) begin
         bad++;
         $display("FAIL shl3: out=%h c=%b, want %h %b", obs_out, obs_c, e.out, e.c);
      end
      total++;
      if (obs_busy !== (BARREL ? 0 : 2) || obs_cyc !== (BARREL ? 1 : 3)) begin
         bad++;
         $display("FAIL shl3_timing: busy=%0d cyc=%0d, want %0d %0d", obs_busy, obs_cyc, BARREL ? 0 : 2, BARREL ? 1 : 3);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL shl3_done_pulse: done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_asr_ror();
      run_op(3'd1, '0, 1'b0, 16'h8000, 1'b0);
      sb.push_back(exp_t'{16'hF800, 1'b0});
      run_op(3'd6, 4'd4, 1'b1, '0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c} !== {e.out, e.c}) begin
         bad++;
         $display("FAIL asr4: out=%h c=%b, want %h %b", obs_out, obs_c, e.out, e.c);
      end
      run_op(3'd1, '0, 1'b0, 16'h0001, 1'b0);
      sb.push_back(exp_t'{16'h8000, 1'b1});
      run_op(3'd7, 4'd1, 1'b0, '0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c} !== {e.out, e.c} || obs_cyc !== 1 || obs_busy !== 0) begin
         bad++;
         $display("FAIL ror1: out=%h c=%b cyc=%0d busy=%0d, want %h %b 1 0", obs_out, obs_c, obs_cyc, obs_busy, e.out, e.c);
      end
   endtask

   task automatic test_dec_shr0();
      run_op(3'd0, '0, 1'b0, '0, 1'b0);
      sb.push_back(exp_t'{16'hFFFF, 1'b1});
      run_op(3'd3, '0, 1'b0, '0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c} !== {e.out, e.c}) begin
         bad++;
         $display("FAIL dec_wrap: out=%h c=%b, want %h %b", obs_out, obs_c, e.out, e.c);
      end
      run_op(3'd1, '0, 1'b0, 16'h2469, 1'b0);
      sb.push_back(exp_t'{16'h1234, 1'b1});
      run_op(3'd4, 4'd1, 1'b0, '0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c} !== {e.out, e.c}) begin
         bad++;
         $display("FAIL shr1: out=%h c=%b, want %h %b", obs_out, obs_c, e.out, e.c);
      end
      sb.push_back(exp_t'{16'h1234, 1'b1});
      run_op(3'd4, 4'd0, 1'b1, '0, 1'b0);
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c} !== {e.out, e.c} || obs_cyc !== 1 || obs_busy !== 0) begin
         bad++;
         $display("FAIL shr0: out=%h c=%b cyc=%0d busy=%0d, want %h %b 1 0", obs_out, obs_c, obs_cyc, obs_busy, e.out, e.c);
      end
   endtask

   task automatic test_busy_ignore();
      int dones = 0;
      run_op(3'd1, '0, 1'b0, 16'hFF00, 1'b0);
      sb.push_back(exp_t'{16'h01FE, 1'b0});
      @(negedge clk);
      start = 1'b1; op = 3'd4; amt = 4'd7; ser_in = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      obs_out = 'x; obs_c = 1'bx;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!BARREL && i == 1) begin start = 1'b1; op = 3'd1; in = 16'hAAAA; end
         if (i == 2) start = 1'b0;
         if (done) begin
            dones++;
            obs_out = out; obs_c = carry;
         end
      end
      e = sb.pop_front();
      total++;
      if ({obs_out, obs_c} !== {e.out, e.c}) begin
         bad++;
         $display("FAIL shr7_busy_ld: out=%h c=%b, want %h %b", obs_out, obs_c, e.out, e.c);
      end
      total++;
      if (dones !== 1 || out !== 16'h01FE) begin
         bad++;
         $display("FAIL shr7_ld_not_queued: dones=%0d out=%h, want 1 01fe", dones, out);
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      run_op(3'd1, '0, 1'b0, 16'hFF00, 1'b0);
      @(negedge clk);
      start = 1'b1; op = 3'd4; amt = 4'd7; ser_in = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({out, carry, busy, done, zero} !== {16'h0000, 4'b0001}) begin
         bad++;
         $display("FAIL mid_reset: out=%h c=%b busy=%b done=%b zero=%b, want 0000 0 0 0 1", out, carry, busy, done, zero);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      total++;
      if (dones !== 0 || out !== 16'h0000) begin
         bad++;
         $display("FAIL mid_reset_no_resume: done/busy cycles=%0d out=%h, want 0 0000", dones, out);
      end
   endtask

   task automatic test_back_to_back();
      logic [W:0]    m;
      logic [W-1:0]  cur_out = '0;
      logic          cur_c = 1'b0;
      logic [2:0]    o;
      logic [AW-1:0] a;
      logic          f;
      logic [W-1:0]  d;
      for (int k = 0; k < 40; k++) begin
         o = (k == 0) ? 3'd0 : 3'($urandom);
         a = AW'($urandom); f = 1'($urandom); d = W'($urandom);
         m = model(o, a, f, d, cur_out, cur_c);
         cur_c = m[W]; cur_out = m[W-1:0];
         sb.push_back(exp_t'{cur_out, cur_c});
         run_op(o, a, f, d, k != 0);
         e = sb.pop_front();
         total++;
         if ({obs_out, obs_c} !== {e.out, e.c}) begin
            bad++;
            $display("FAIL b2b[%0d] op=%0d amt=%0d fill=%b: out=%h c=%b, want %h %b", k, o, a, f, obs_out, obs_c, e.out, e.c);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ld_inc();
      test_shl();
      test_asr_ror();
      test_dec_shr0();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
